// File: rtl/muldiv_hilo_unit_if.sv
// Handshake and HI/LO write-port bundle between decode, the mul/div unit and the HI/LO pair.
interface muldiv_hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             cancel;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] hi_wdata;
  logic [WIDTH-1:0] lo_wdata;

  modport master (
    output start, cancel, op, a, b,
    input  busy, hi_we, lo_we, hi_wdata, lo_wdata
  );

  modport slave (
    input  start, cancel, op, a, b,
    output busy, hi_we, lo_we, hi_wdata, lo_wdata
  );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit driving the HI/LO write ports.
// Define MULDIV_FAST_MULT_EN to compute multiplies in a single step (IDLE -> DONE).
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one shift-add / restoring-divide iteration per edge
// DONE  | single-cycle HI/LO write pulse
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  muldiv_hilo_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               divz_q, divz_d;
  logic [WIDTH-1:0]   a_orig_q, a_orig_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, step;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quo, rem, div_lo, div_hi;

  assign sign_a = ~bus.op[0] & bus.a[WIDTH-1];
  assign sign_b = ~bus.op[0] & bus.b[WIDTH-1];
  assign abs_a  = sign_a ? -bus.a : bus.a;
  assign abs_b  = sign_b ? -bus.b : bus.b;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient}, shifted left each step.
  assign div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
  assign div_next = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign step    = is_div_q ? div_next : mul_next;
  assign mul_res = neg_q ? -step : step;
  assign quo     = step[WIDTH-1:0];
  assign rem     = step[2*WIDTH-1:WIDTH];
  assign div_lo  = divz_q ? {WIDTH{1'b1}} : (neg_q ? -quo : quo);
  assign div_hi  = divz_q ? a_orig_q : (rem_neg_q ? -rem : rem);

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] a_ext, b_ext, fast_prod;
  // Low 2W bits of the product of sign/zero-extended operands are exact for both signednesses.
  assign a_ext     = bus.op[0] ? {{WIDTH{1'b0}}, bus.a} : {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
  assign b_ext     = bus.op[0] ? {{WIDTH{1'b0}}, bus.b} : {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
  assign fast_prod = a_ext * b_ext;
`endif

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    divz_d    = divz_q;
    a_orig_d  = a_orig_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.cancel) begin
          is_div_d  = bus.op[1];
          neg_d     = sign_a ^ sign_b;
          rem_neg_d = sign_a;
          divz_d    = bus.op[1] && (bus.b == '0);
          a_orig_d  = bus.a;
          cnt_d     = '0;
          if (bus.op[1]) begin
            acc_d  = {{WIDTH{1'b0}}, abs_a};
            opnd_d = abs_b;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, abs_b};
            opnd_d = abs_a;
          end
          state_d = CALC;
`ifdef MULDIV_FAST_MULT_EN
          if (!bus.op[1]) begin
            {hi_d, lo_d} = fast_prod;
            state_d      = DONE;
          end
`endif
        end
      end
      CALC: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = DONE;
            if (is_div_q) begin
              hi_d = div_hi;
              lo_d = div_lo;
            end else begin
              {hi_d, lo_d} = mul_res;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      divz_q    <= 1'b0;
      a_orig_q  <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      divz_q    <= divz_d;
      a_orig_q  <= a_orig_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.hi_we    = (state_q == DONE) && !bus.cancel;
  assign bus.lo_we    = (state_q == DONE) && !bus.cancel;
  assign bus.hi_wdata = hi_q;
  assign bus.lo_wdata = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: directed corner cases plus random ops vs. an arithmetic model.
module tb_muldiv_hilo_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [63:0] exp_q[$];
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  muldiv_hilo_unit_if #(.WIDTH(W)) bus();
  muldiv_hilo_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results straight from the arithmetic definitions; returns {hi, lo}.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: return sa * sb;
      2'b01: return ua * ub;
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = longint'(ua / ub);
          r = longint'(ua % ub);
        end
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Monitor: every write pulse must match the oldest outstanding expectation.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && (bus.hi_we || bus.lo_we)) begin
        chk("we_pair", {63'd0, bus.lo_we}, {63'd0, bus.hi_we});
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("hi_wdata", {32'd0, bus.hi_wdata}, {32'd0, e[63:32]});
          chk("lo_wdata", {32'd0, bus.lo_wdata}, {32'd0, e[31:0]});
        end
      end
    end
  end

  task automatic run_op(input logic [1:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                        input int cancel_at, input int start2_at, input int rst_at);
    int n = 0;
    int lat = W + 1;
    bit done = 0;
    logic [63:0] e;
`ifdef MULDIV_FAST_MULT_EN
    if (!op_v[1]) lat = 1;
`endif
    e = ref_model(op_v, a_v, b_v);
    if (cancel_at == 0 && rst_at == 0) exp_q.push_back(e);
    bus.op = op_v;
    bus.a = a_v;
    bus.b = b_v;
    bus.start = 1'b1;
    while (!done && n < 2 * W) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.start = 1'b0;
        bus.op = 2'($urandom_range(0, 3));
        bus.a = $urandom;
        bus.b = $urandom;
        chk("busy_c1", {63'd0, bus.busy}, 64'd1);
      end
      if (n == start2_at) begin
        bus.start = 1'b1;
        bus.a = 32'd50;
        bus.b = 32'd3;
      end
      if (n == start2_at + 1) bus.start = 1'b0;
      if (n == cancel_at) begin
        bus.cancel = 1'b1;
        #1;
        chk("cancel_we", {62'd0, bus.hi_we, bus.lo_we}, 64'd0);
        @(negedge clk);
        bus.cancel = 1'b0;
        chk("cancel_busy", {63'd0, bus.busy}, 64'd0);
        if (cancel_at <= W) chk("cancel_hold", {bus.hi_wdata, bus.lo_wdata}, {last_hi, last_lo});
        done = 1;
      end else if (n == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_outs", {29'd0, bus.busy, bus.hi_we, bus.lo_we, bus.hi_wdata | bus.lo_wdata}, 64'd0);
        last_hi = '0;
        last_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        done = 1;
      end else if (bus.hi_we) begin
        chk("latency", 64'(n), 64'(lat));
        last_hi = e[63:32];
        last_lo = e[31:0];
        @(negedge clk);
        chk("busy_after", {63'd0, bus.busy}, 64'd0);
        chk("hold", {bus.hi_wdata, bus.lo_wdata}, {last_hi, last_lo});
        done = 1;
      end
    end
    if (!done) chk("timeout", 64'd1, 64'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", {29'd0, bus.busy, bus.hi_we, bus.lo_we, bus.hi_wdata | bus.lo_wdata}, 64'd0);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    run_op(2'b11, 32'd100, 32'd0, 0, 0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 0, 0, 0);
    run_op(2'b11, 32'd1000, 32'd7, 10, 0, 0);
    run_op(2'b11, 32'd1000, 32'd7, 0, 0, 0);
    run_op(2'b11, 32'd1000, 32'd7, 0, 5, 0);
    run_op(2'b11, 32'd12345, 32'd11, W + 1, 0, 0);

    // cancel together with start in IDLE: not accepted
    bus.op = 2'b11;
    bus.a = 32'd9;
    bus.b = 32'd2;
    bus.start = 1'b1;
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    chk("cancel_wins", {63'd0, bus.busy}, 64'd0);

`ifdef MULDIV_FAST_MULT_EN
    run_op(2'b11, 32'd123456, 32'd789, 0, 0, 20);
`else
    run_op(2'b01, 32'd123456, 32'd789, 0, 0, 20);
`endif
    run_op(2'b01, 32'd6, 32'd7, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = (($urandom_range(0, 7)) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, 0, 0, 0);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
